// File: rtl/slice_height_sequencer.sv
// -----------------------------------------------------------------------------
// slice_height_sequencer
//
// Frame-level slice-height sequencer. On start it walks every screen column
// 0..NUM_COLS-1. For each column it fetches wall-intersection distances from
// the raycast engines (req/ack), picks the nearer hit, applies fisheye
// correction (d * cos_beta), divides PROJ_CONST by the corrected distance with
// a one-bit-per-cycle restoring divider, clamps the result and hands one slice
// per column to the renderer over a valid/ready stream.
//
// Ports
//   clock, reset      : rising-edge clock, asynchronous active-high reset
//   start             : begin a frame (only honoured while idle)
//   abort             : synchronous return to idle from any active state
//   busy              : high in every state except idle
//   frame_done        : one-cycle pulse after the last column is accepted
//   ray_req/ray_col   : intersection request for a column
//   ray_ack           : engine result valid; ray_hit_*, dist_*, cos_beta are
//                       captured on the cycle ray_ack=1 while ray_req=1
//   slice_valid/ready : slice stream handshake to the column renderer
//   slice_col         : column of the emitted slice
//   slice_height      : clamped projected wall height
// -----------------------------------------------------------------------------
module slice_height_sequencer #(
  parameter int NUM_COLS   = 160,
  parameter int COL_W      = 8,
  parameter int DIST_W     = 13,
  parameter int FRAC_W     = 9,
  parameter int HEIGHT_W   = 7,
  parameter int PROJ_CONST = 8896,
  parameter int MAX_HEIGHT = 120
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                frame_done,
  output logic                ray_req,
  output logic [COL_W-1:0]    ray_col,
  input  logic                ray_ack,
  input  logic                ray_hit_h,
  input  logic                ray_hit_v,
  input  logic [DIST_W-1:0]   dist_h,
  input  logic [DIST_W-1:0]   dist_v,
  input  logic [FRAC_W:0]     cos_beta,
  output logic                slice_valid,
  input  logic                slice_ready,
  output logic [COL_W-1:0]    slice_col,
  output logic [HEIGHT_W-1:0] slice_height
);

  // Quotient width: enough bits to hold PROJ_CONST itself (divisor of 1).
  localparam int PW    = $clog2(PROJ_CONST + 1);
  // Corrected distance can reach ~2*d since cos_beta is Q1.FRAC_W.
  localparam int CW    = DIST_W + 1;
  localparam int PRODW = DIST_W + FRAC_W + 1;
  localparam int CNTW  = (PW > 1) ? $clog2(PW) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_SELECT,
    S_CORRECT,
    S_DIVIDE,
    S_OUTPUT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic                hit_h_q, hit_h_d;
  logic                hit_v_q, hit_v_d;
  logic [DIST_W-1:0]   dist_h_q, dist_h_d;
  logic [DIST_W-1:0]   dist_v_q, dist_v_d;
  logic [DIST_W-1:0]   dsel_q, dsel_d;
  logic [FRAC_W:0]     cos_q, cos_d;
  logic [CW-1:0]       corr_q, corr_d;
  logic [CW-1:0]       rem_q, rem_d;
  logic [PW-1:0]       quo_q, quo_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [HEIGHT_W-1:0] height_q, height_d;

  logic [PRODW-1:0]    prod;
  logic [CW:0]         trial;
  logic                qbit;

  // Truncating fisheye correction; a zero result becomes 1 so the divider
  // never sees a zero divisor.
  function automatic logic [CW-1:0] fisheye_corr(input logic [PRODW-1:0] p);
    logic [CW-1:0] c;
    c = CW'(p >> FRAC_W);
    if (c == '0) c = CW'(1);
    return c;
  endfunction

  // Saturate the quotient to the tallest drawable slice.
  function automatic logic [HEIGHT_W-1:0] sat_height(input logic [PW-1:0] q);
    if (32'(q) > 32'(MAX_HEIGHT)) return HEIGHT_W'(MAX_HEIGHT);
    return HEIGHT_W'(q);
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      col_q    <= '0;
      hit_h_q  <= 1'b0;
      hit_v_q  <= 1'b0;
      dist_h_q <= '0;
      dist_v_q <= '0;
      dsel_q   <= '0;
      cos_q    <= '0;
      corr_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      height_q <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      hit_h_q  <= hit_h_d;
      hit_v_q  <= hit_v_d;
      dist_h_q <= dist_h_d;
      dist_v_q <= dist_v_d;
      dsel_q   <= dsel_d;
      cos_q    <= cos_d;
      corr_q   <= corr_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      height_q <= height_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    hit_h_d  = hit_h_q;
    hit_v_d  = hit_v_q;
    dist_h_d = dist_h_q;
    dist_v_d = dist_v_q;
    dsel_d   = dsel_q;
    cos_d    = cos_q;
    corr_d   = corr_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    height_d = height_q;

    busy        = (state_q != S_IDLE);
    ray_req     = (state_q == S_REQ);
    slice_valid = (state_q == S_OUTPUT);
    frame_done  = (state_q == S_DONE);

    prod  = PRODW'(dsel_q) * PRODW'(cos_q);
    // Restoring step: shift the next dividend bit into the partial remainder.
    trial = {rem_q, quo_q[PW-1]};
    qbit  = (trial >= {1'b0, corr_q});

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_REQ;
          col_d   = '0;
        end
      end
      S_REQ: begin
        if (ray_ack) begin
          hit_h_d  = ray_hit_h;
          hit_v_d  = ray_hit_v;
          dist_h_d = dist_h;
          dist_v_d = dist_v;
          cos_d    = cos_beta;
          state_d  = S_SELECT;
        end
      end
      S_SELECT: begin
        if (!hit_h_q && !hit_v_q) begin
          height_d = '0;
          state_d  = S_OUTPUT;
        end else begin
          // On equal distances the horizontal hit wins.
          if (hit_h_q && hit_v_q)
            dsel_d = (dist_v_q < dist_h_q) ? dist_v_q : dist_h_q;
          else if (hit_h_q)
            dsel_d = dist_h_q;
          else
            dsel_d = dist_v_q;
          state_d = S_CORRECT;
        end
      end
      S_CORRECT: begin
        corr_d  = fisheye_corr(prod);
        rem_d   = '0;
        quo_d   = PW'(PROJ_CONST);
        cnt_d   = '0;
        state_d = S_DIVIDE;
      end
      S_DIVIDE: begin
        // quo_q shifts dividend bits out the top and quotient bits in the bottom.
        rem_d = qbit ? CW'(trial - {1'b0, corr_q}) : CW'(trial);
        quo_d = {quo_q[PW-2:0], qbit};
        cnt_d = cnt_q + CNTW'(1);
        if (cnt_q == CNTW'(PW - 1)) begin
          height_d = sat_height({quo_q[PW-2:0], qbit});
          state_d  = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (slice_ready) begin
          if (col_q == COL_W'(NUM_COLS - 1)) begin
            state_d = S_DONE;
          end else begin
            col_d   = col_q + COL_W'(1);
            state_d = S_REQ;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides every transition, including a coincident ack or handshake.
    if (abort && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  assign ray_col      = col_q;
  assign slice_col    = col_q;
  assign slice_height = height_q;

endmodule

// File: tb/tb_slice_height_sequencer.sv
module tb_slice_height_sequencer;

  localparam int NUM_COLS   = 4;
  localparam int COL_W      = 8;
  localparam int DIST_W     = 13;
  localparam int FRAC_W     = 9;
  localparam int HEIGHT_W   = 7;
  localparam int PROJ_CONST = 8896;
  localparam int MAX_HEIGHT = 120;
  localparam int PW         = $clog2(PROJ_CONST + 1);
  localparam int CB_W       = FRAC_W + 1;

  logic                clock = 1'b0;
  logic                reset;
  logic                start;
  logic                abort;
  logic                busy;
  logic                frame_done;
  logic                ray_req;
  logic [COL_W-1:0]    ray_col;
  logic                ray_ack;
  logic                ray_hit_h;
  logic                ray_hit_v;
  logic [DIST_W-1:0]   dist_h;
  logic [DIST_W-1:0]   dist_v;
  logic [CB_W-1:0]     cos_beta;
  logic                slice_valid;
  logic                slice_ready;
  logic [COL_W-1:0]    slice_col;
  logic [HEIGHT_W-1:0] slice_height;

  slice_height_sequencer #(
    .NUM_COLS(NUM_COLS), .COL_W(COL_W), .DIST_W(DIST_W), .FRAC_W(FRAC_W),
    .HEIGHT_W(HEIGHT_W), .PROJ_CONST(PROJ_CONST), .MAX_HEIGHT(MAX_HEIGHT)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .busy(busy), .frame_done(frame_done),
    .ray_req(ray_req), .ray_col(ray_col), .ray_ack(ray_ack),
    .ray_hit_h(ray_hit_h), .ray_hit_v(ray_hit_v),
    .dist_h(dist_h), .dist_v(dist_v), .cos_beta(cos_beta),
    .slice_valid(slice_valid), .slice_ready(slice_ready),
    .slice_col(slice_col), .slice_height(slice_height)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit hh;
    bit hv;
    int dh;
    int dv;
    int cosb;
    int exp_h;
    int exp_lat;
  } vec_t;

  vec_t tbl [16];
  vec_t fv  [NUM_COLS];

  int n_cmp = 0;
  int n_bad = 0;
  int fd_count = 0;

  always @(negedge clock) if (frame_done) fd_count <= fd_count + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: nearer hit, truncating fisheye, integer divide, clamp.
  function automatic int ref_height(input bit hh, input bit hv, input int dh,
                                    input int dv, input int cosb);
    longint d, corr, q;
    if (!hh && !hv) return 0;
    if (hh && hv) d = (dv < dh) ? dv : dh;
    else if (hh)  d = dh;
    else          d = dv;
    corr = (d * cosb) / (64'd1 << FRAC_W);
    if (corr == 0) corr = 1;
    q = PROJ_CONST / corr;
    return (q > MAX_HEIGHT) ? MAX_HEIGHT : int'(q);
  endfunction

  function automatic vec_t mk(input bit hh, input bit hv, input int dh,
                              input int dv, input int cosb, input int eh, input int el);
    vec_t v;
    v.hh = hh; v.hv = hv; v.dh = dh; v.dv = dv; v.cosb = cosb;
    v.exp_h = eh; v.exp_lat = el;
    return v;
  endfunction

  task automatic drive_garbage();
    ray_hit_h = 1'($urandom_range(0, 1));
    ray_hit_v = 1'($urandom_range(0, 1));
    dist_h    = DIST_W'($urandom);
    dist_v    = DIST_W'($urandom);
    cos_beta  = CB_W'($urandom);
  endtask

  task automatic drive_result(input vec_t v);
    ray_hit_h = v.hh;
    ray_hit_v = v.hv;
    dist_h    = DIST_W'(v.dh);
    dist_v    = DIST_W'(v.dv);
    cos_beta  = CB_W'(v.cosb);
    ray_ack   = 1'b1;
  endtask

  task automatic wait_req(input string tag, input int exp_col);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (ray_req) begin ok = 1'b1; break; end
    end
    chk({tag, " req_seen"}, int'(ok), 1);
    chk({tag, " ray_col"}, int'(ray_col), exp_col);
  endtask

  // Serve one column: answer the request, measure ack->valid latency,
  // optionally stall the renderer, then accept the slice.
  task automatic serve_column(input vec_t v, input int exp_col, input int ack_dly,
                              input int ready_low, input string tag);
    int  n;
    bit  ok;
    int  c0, h0;
    bit  stable;
    wait_req(tag, exp_col);
    if (ack_dly > 0) begin
      repeat (ack_dly) @(negedge clock);
      chk({tag, " req_held"}, int'(ray_req), 1);
    end
    if (ready_low > 0) slice_ready = 1'b0;
    drive_result(v);
    @(negedge clock);
    ray_ack = 1'b0;
    drive_garbage();
    chk({tag, " req_drop"}, int'(ray_req), 0);
    n = 1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      n++;
      if (slice_valid) begin ok = 1'b1; break; end
    end
    chk({tag, " valid_seen"}, int'(ok), 1);
    chk({tag, " latency"}, n - 1, v.exp_lat);
    chk({tag, " slice_col"}, int'(slice_col), exp_col);
    chk({tag, " height"}, int'(slice_height), v.exp_h);
    if (ready_low > 0) begin
      c0 = int'(slice_col);
      h0 = int'(slice_height);
      stable = 1'b1;
      repeat (ready_low) begin
        @(negedge clock);
        if (!slice_valid || ray_req || int'(slice_col) != c0 || int'(slice_height) != h0)
          stable = 1'b0;
      end
      chk({tag, " backpressure_hold"}, int'(stable), 1);
      slice_ready = 1'b1;
    end
    @(negedge clock);
    chk({tag, " valid_drop"}, int'(slice_valid), 0);
  endtask

  task automatic run_frame(input int bp_col, input bit rnd, input string tag);
    int fd0, dly, bp;
    fd0 = fd_count;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int c = 0; c < NUM_COLS; c++) begin
      dly = rnd ? int'($urandom_range(0, 3)) : 0;
      bp  = (c == bp_col) ? 5 : (rnd ? int'($urandom_range(0, 2)) : 0);
      serve_column(fv[c], c, dly, bp, tag);
    end
    repeat (2) @(negedge clock);
    chk({tag, " frame_done_pulses"}, fd_count - fd0, 1);
    chk({tag, " busy_after_frame"}, int'(busy), 0);
  endtask

  task automatic fill_default();
    for (int c = 0; c < NUM_COLS; c++) fv[c] = mk(1, 0, 100, 0, 512, 88, 2 + PW);
  endtask

  initial begin
    int fd0;
    bit seen;
    int hh, hv, dh, dv, cb;

    tbl[0]  = mk(1, 0, 100,  0,    512, 88,  16);
    tbl[1]  = mk(1, 0, 100,  0,    512, 88,  16);
    tbl[2]  = mk(1, 0, 100,  0,    512, 88,  16);
    tbl[3]  = mk(1, 0, 100,  0,    512, 88,  16);
    tbl[4]  = mk(1, 1, 200,  150,  256, 118, 16);
    tbl[5]  = mk(1, 1, 300,  300,  512, 29,  16);
    tbl[6]  = mk(0, 0, 77,   99,   512, 0,   1);
    tbl[7]  = mk(1, 0, 0,    0,    512, 120, 16);
    tbl[8]  = mk(0, 1, 5,    50,   512, 120, 16);
    tbl[9]  = mk(0, 1, 5,    400,  512, 22,  16);
    tbl[10] = mk(1, 1, 100,  8000, 512, 88,  16);
    tbl[11] = mk(1, 0, 8191, 0,    1023, 0,  16);
    tbl[12] = mk(1, 0, 1,    0,    511, 120, 16);
    tbl[13] = mk(1, 1, 1000, 999,  512, 8,   16);
    tbl[14] = mk(0, 1, 0,    74,   512, 120, 16);
    tbl[15] = mk(1, 0, 75,   0,    512, 118, 16);

    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    ray_ack = 1'b0;
    slice_ready = 1'b1;
    drive_garbage();
    repeat (2) @(negedge clock);
    chk("reset busy", int'(busy), 0);
    chk("reset ray_req", int'(ray_req), 0);
    chk("reset slice_valid", int'(slice_valid), 0);
    chk("reset frame_done", int'(frame_done), 0);
    chk("reset slice_height", int'(slice_height), 0);
    chk("reset ray_col", int'(ray_col), 0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle busy", int'(busy), 0);

    // Table-driven frames; frame 1 stalls column 1 for five cycles.
    for (int f = 0; f < 4; f++) begin
      for (int c = 0; c < NUM_COLS; c++) fv[c] = tbl[f * NUM_COLS + c];
      run_frame((f == 1) ? 1 : -1, 1'b0, $sformatf("tbl_f%0d", f));
    end

    // Start while busy is ignored.
    fill_default();
    fd0 = fd_count;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    serve_column(fv[0], 0, 0, 0, "busy_start c0");
    start = 1'b1;
    repeat (2) @(negedge clock);
    start = 1'b0;
    chk("busy_start ray_col", int'(ray_col), 1);
    chk("busy_start ray_req", int'(ray_req), 1);
    for (int c = 1; c < NUM_COLS; c++) serve_column(fv[c], c, 0, 0, "busy_start");
    repeat (2) @(negedge clock);
    chk("busy_start frame_done_pulses", fd_count - fd0, 1);

    // Abort coincident with ray_ack wins.
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    drive_result(fv[0]);
    abort = 1'b1;
    @(negedge clock);
    ray_ack = 1'b0;
    abort = 1'b0;
    chk("abort_ack busy", int'(busy), 0);
    chk("abort_ack ray_req", int'(ray_req), 0);
    @(negedge clock);
    chk("abort_ack stays_idle", int'(busy), 0);

    // Abort in the middle of the divide for column 2.
    fd0 = fd_count;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    serve_column(fv[0], 0, 0, 0, "abort_div c0");
    serve_column(fv[1], 1, 0, 0, "abort_div c1");
    wait_req("abort_div c2", 2);
    drive_result(fv[2]);
    @(negedge clock);
    ray_ack = 1'b0;
    drive_garbage();
    repeat (6) @(negedge clock);
    chk("abort_div busy_before", int'(busy), 1);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("abort_div busy", int'(busy), 0);
    chk("abort_div ray_req", int'(ray_req), 0);
    chk("abort_div slice_valid", int'(slice_valid), 0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (slice_valid || ray_req || busy) seen = 1'b1;
    end
    chk("abort_div stays_idle", int'(seen), 0);
    chk("abort_div no_frame_done", fd_count - fd0, 0);
    run_frame(-1, 1'b0, "after_abort");

    // Asynchronous reset between clock edges while a slice is stalled.
    fd0 = fd_count;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    serve_column(fv[0], 0, 0, 0, "areset c0");
    wait_req("areset c1", 1);
    slice_ready = 1'b0;
    drive_result(fv[1]);
    @(negedge clock);
    ray_ack = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (slice_valid) begin seen = 1'b1; break; end
    end
    chk("areset valid_before", int'(seen), 1);
    chk("areset col_before", int'(slice_col), 1);
    chk("areset height_before", int'(slice_height), 88);
    #2;
    reset = 1'b1;
    #1;
    chk("areset busy", int'(busy), 0);
    chk("areset slice_valid", int'(slice_valid), 0);
    chk("areset slice_col", int'(slice_col), 0);
    chk("areset slice_height", int'(slice_height), 0);
    chk("areset ray_req", int'(ray_req), 0);
    @(negedge clock);
    reset = 1'b0;
    slice_ready = 1'b1;
    repeat (3) @(negedge clock);
    chk("areset no_frame_done", fd_count - fd0, 0);
    run_frame(-1, 1'b0, "after_reset");

    // Randomized frames against the reference model.
    for (int f = 0; f < 8; f++) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        hh = int'($urandom_range(0, 1));
        hv = int'($urandom_range(0, 1));
        dh = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 200)) : int'($urandom_range(0, 8191));
        dv = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 200)) : int'($urandom_range(0, 8191));
        cb = int'($urandom_range(0, 1023));
        fv[c] = mk(hh[0], hv[0], dh, dv, cb,
                   ref_height(hh[0], hv[0], dh, dv, cb),
                   (hh != 0 || hv != 0) ? 2 + PW : 1);
      end
      run_frame(-1, 1'b1, $sformatf("rnd_f%0d", f));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
